// File: rtl/memory_cycle.sv
// memory_cycle: M stage with word-addressed data RAM and M/W pipeline register; MEM_PARITY_EN adds stored even parity and a sticky ParityErr.
module memory_cycle #(
  parameter int ADDR_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegwriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic        MemwriteM,
  input  logic [2:0]  RdM,
  input  logic [15:0] ALUResultM,
  input  logic [15:0] WriteDataM,
  input  logic [15:0] pc_plus4M,
  output logic        RegwriteW,
  output logic [1:0]  ResultSrcW,
  output logic [2:0]  RdW,
  output logic [15:0] ALUResultW,
  output logic [15:0] ReadDataW,
  output logic [15:0] pc_plus4W,
  output logic        ParityErr
);
`ifdef MEM_PARITY_EN
  localparam int RW = 17;
`else
  localparam int RW = 16;
`endif
  logic [RW-1:0]     mem [2**ADDR_W];
  logic [ADDR_W-1:0] addr;
  logic [RW-1:0]     rd_word, wr_word;
  logic              regwrite_d, regwrite_q;
  logic [1:0]        result_src_d, result_src_q;
  logic [2:0]        rd_d, rd_q;
  logic [15:0]       alu_result_d, alu_result_q;
  logic [15:0]       read_data_d, read_data_q;
  logic [15:0]       pc_plus4_d, pc_plus4_q;
  always_comb begin
    addr = ALUResultM[ADDR_W-1:0];
    rd_word = mem[addr];
`ifdef MEM_PARITY_EN
    wr_word = {^WriteDataM, WriteDataM};
`else
    wr_word = WriteDataM;
`endif
    regwrite_d = RegwriteM;
    result_src_d = ResultSrcM;
    rd_d = RdM;
    alu_result_d = ALUResultM;
    read_data_d = rd_word[15:0];
    pc_plus4_d = pc_plus4M;
  end
  always_ff @(posedge clk)
    if (rst && MemwriteM) mem[addr] <= wr_word;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regwrite_q <= 1'b0;
      result_src_q <= 2'b00;
      rd_q <= 3'd0;
      alu_result_q <= 16'd0;
      read_data_q <= 16'd0;
      pc_plus4_q <= 16'd0;
    end else begin
      regwrite_q <= regwrite_d;
      result_src_q <= result_src_d;
      rd_q <= rd_d;
      alu_result_q <= alu_result_d;
      read_data_q <= read_data_d;
      pc_plus4_q <= pc_plus4_d;
    end
  end
`ifdef MEM_PARITY_EN
  logic parity_err_d, parity_err_q;
  // an odd 17-bit word means the stored parity no longer matches its data
  always_comb parity_err_d = parity_err_q | ((ResultSrcM == 2'b01) & (^rd_word));
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) parity_err_q <= 1'b0;
    else parity_err_q <= parity_err_d;
  end
  assign ParityErr = rst ? parity_err_q : 1'b0;
`else
  assign ParityErr = 1'b0;
`endif
  assign RegwriteW  = rst ? regwrite_q : 1'b0;
  assign ResultSrcW = rst ? result_src_q : 2'b00;
  assign RdW        = rst ? rd_q : 3'd0;
  assign ALUResultW = rst ? alu_result_q : 16'd0;
  assign ReadDataW  = rst ? read_data_q : 16'd0;
  assign pc_plus4W  = rst ? pc_plus4_q : 16'd0;
endmodule

// File: tb/tb_memory_cycle.sv
// tb_memory_cycle: table-driven checks of memory_cycle plus reset, dropped-store and parity sequences.
module tb_memory_cycle;
  logic        clk = 1'b0, rst = 1'b0;
  logic        RegwriteM, MemwriteM;
  logic [1:0]  ResultSrcM;
  logic [2:0]  RdM;
  logic [15:0] ALUResultM, WriteDataM, pc_plus4M;
  logic        RegwriteW, ParityErr;
  logic [1:0]  ResultSrcW;
  logic [2:0]  RdW;
  logic [15:0] ALUResultW, ReadDataW, pc_plus4W;
  int n_tests = 0, n_fail = 0;
  logic exp_perr = 1'b0;
  typedef struct {
    logic        rw;
    logic [1:0]  rs;
    logic        mw;
    logic [2:0]  rd;
    logic [15:0] alu, wd, pc4;
    logic        chk_rd;
    logic [15:0] e_rdata;
  } vec_t;
  vec_t tv [10];
  vec_t v;
  memory_cycle #(.ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .RegwriteM(RegwriteM), .ResultSrcM(ResultSrcM),
    .MemwriteM(MemwriteM), .RdM(RdM), .ALUResultM(ALUResultM),
    .WriteDataM(WriteDataM), .pc_plus4M(pc_plus4M), .RegwriteW(RegwriteW),
    .ResultSrcW(ResultSrcW), .RdW(RdW), .ALUResultW(ALUResultW),
    .ReadDataW(ReadDataW), .pc_plus4W(pc_plus4W), .ParityErr(ParityErr)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic drive(input logic r, input vec_t x);
    rst = r;
    RegwriteM = x.rw;
    ResultSrcM = x.rs;
    MemwriteM = x.mw;
    RdM = x.rd;
    ALUResultM = x.alu;
    WriteDataM = x.wd;
    pc_plus4M = x.pc4;
  endtask
  task automatic check_outs(input string tag, input vec_t x, input logic zero);
    chk({tag, "_regw"}, {15'd0, RegwriteW}, zero ? 16'd0 : {15'd0, x.rw});
    chk({tag, "_rsrc"}, {14'd0, ResultSrcW}, zero ? 16'd0 : {14'd0, x.rs});
    chk({tag, "_rd"}, {13'd0, RdW}, zero ? 16'd0 : {13'd0, x.rd});
    chk({tag, "_alu"}, ALUResultW, zero ? 16'd0 : x.alu);
    chk({tag, "_pc4"}, pc_plus4W, zero ? 16'd0 : x.pc4);
    if (zero || x.chk_rd) chk({tag, "_rdata"}, ReadDataW, zero ? 16'd0 : x.e_rdata);
    chk({tag, "_perr"}, {15'd0, ParityErr}, zero ? 16'd0 : {15'd0, exp_perr});
  endtask
  task automatic step(input string tag, input logic r, input vec_t x);
    @(negedge clk);
    drive(r, x);
    @(posedge clk);
    #1;
    check_outs(tag, x, !r);
  endtask
  initial begin
    //        rw    rs     mw    rd    alu       wd        pc4       chk   rdata
    tv[0] = '{1'b0, 2'b00, 1'b1, 3'd0, 16'h0005, 16'hBEEF, 16'h0000, 1'b0, 16'h0000};
    tv[1] = '{1'b1, 2'b01, 1'b0, 3'd2, 16'h0005, 16'h0000, 16'h0004, 1'b1, 16'hBEEF};
    tv[2] = '{1'b0, 2'b00, 1'b1, 3'd0, 16'h0103, 16'hA5A5, 16'h0008, 1'b0, 16'h0000};
    tv[3] = '{1'b1, 2'b01, 1'b0, 3'd4, 16'h0003, 16'h0000, 16'h000C, 1'b1, 16'hA5A5};
    tv[4] = '{1'b0, 2'b00, 1'b1, 3'd0, 16'h0009, 16'h2222, 16'h0010, 1'b0, 16'h0000};
    tv[5] = '{1'b1, 2'b10, 1'b0, 3'd7, 16'h0005, 16'h0000, 16'h0040, 1'b1, 16'hBEEF};
    tv[6] = '{1'b1, 2'b01, 1'b0, 3'd1, 16'h0009, 16'h0000, 16'h0014, 1'b1, 16'h2222};
    tv[7] = '{1'b0, 2'b01, 1'b1, 3'd0, 16'h0005, 16'h1357, 16'h0018, 1'b1, 16'hBEEF};
    tv[8] = '{1'b1, 2'b01, 1'b0, 3'd6, 16'h0005, 16'h0000, 16'h001C, 1'b1, 16'h1357};
    tv[9] = '{1'b1, 2'b01, 1'b0, 3'd5, 16'hFF03, 16'h0000, 16'h0020, 1'b1, 16'hA5A5};
    v = '{1'b1, 2'b01, 1'b1, 3'd5, 16'h00AA, 16'h7777, 16'h0099, 1'b0, 16'h0000};
    drive(1'b0, v);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_outs($sformatf("rst%0d", i), v, 1'b1);
    end
    v = '{1'b0, 2'b00, 1'b0, 3'd3, 16'h1234, 16'h0000, 16'h0000, 1'b0, 16'h0000};
    step("release", 1'b1, v);
    for (int i = 0; i < 10; i++) step($sformatf("v%0d", i), 1'b1, tv[i]);
    v = '{1'b0, 2'b00, 1'b1, 3'd0, 16'h0009, 16'h1111, 16'h0000, 1'b0, 16'h0000};
    step("drop_rst", 1'b0, v);
    v = '{1'b1, 2'b01, 1'b0, 3'd2, 16'h0009, 16'h0000, 16'h0030, 1'b1, 16'h2222};
    step("drop_load", 1'b1, v);
    v = '{1'b1, 2'b10, 1'b0, 3'd7, 16'h0005, 16'h0000, 16'h0040, 1'b1, 16'h1357};
    step("pre_async", 1'b1, v);
    #2 rst = 1'b0;
    #1 check_outs("async", v, 1'b1);
`ifdef MEM_PARITY_EN
    v = '{1'b0, 2'b00, 1'b1, 3'd0, 16'h000B, 16'h0001, 16'h0000, 1'b0, 16'h0000};
    step("par_store", 1'b1, v);
    @(negedge clk);
    dut.mem[11][0] = ~dut.mem[11][0];
    exp_perr = 1'b1;
    v = '{1'b1, 2'b01, 1'b0, 3'd1, 16'h000B, 16'h0000, 16'h0000, 1'b1, 16'h0000};
    step("par_bad", 1'b1, v);
    v = '{1'b1, 2'b01, 1'b0, 3'd1, 16'h0005, 16'h0000, 16'h0000, 1'b1, 16'h1357};
    for (int i = 0; i < 10; i++) step($sformatf("par_good%0d", i), 1'b1, v);
    #2 rst = 1'b0;
    exp_perr = 1'b0;
    #1 check_outs("par_clr", v, 1'b1);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
